// File: rtl/axi_window_bridge_pkg.sv
// rtl/axi_window_bridge_pkg.sv - shared AXI4-Lite response codes, FSM encodings and helpers
// Purpose: constants shared by the window bridge, its translator and its bench.
// Ports: none (package).
package axi_lite_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Read FSM
  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_ADDR = 3'd1;
  localparam logic [2:0] R_DATA = 3'd2;
  localparam logic [2:0] R_RESP = 3'd3;
  localparam logic [2:0] R_ERR  = 3'd4;

  // Write FSM
  localparam logic [2:0] W_IDLE  = 3'd0;
  localparam logic [2:0] W_FWD   = 3'd1;
  localparam logic [2:0] W_BWAIT = 3'd2;
  localparam logic [2:0] W_RESP  = 3'd3;
  localparam logic [2:0] W_ERR   = 3'd4;

  // Saturating 16-bit add of a small increment (0..3).
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/axi_window_bridge_if.sv
// rtl/axi_window_bridge_if.sv - AXI4-Lite five-channel bundle with master/slave modports
// Purpose: groups one AXI4-Lite port (AR, R, AW, W, B).
// Ports: none; modport master drives requests and response readies,
//        modport slave drives request readies and responses.
interface axi_window_bridge_if;

  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arprot, arvalid, rready,
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_window_bridge_xlate.sv
// rtl/axi_window_bridge_xlate.sv - combinational window hit test and address translation
// Purpose: hit = addr in [BASE, BASE+SIZE); xaddr = ((addr-BASE) << LEFT_SHIFT) + OFFSET.
// Ports: i_addr (32) in, o_hit (1) out, o_xaddr (32) out.
module window_xlate #(
  parameter logic [31:0] BASE       = 32'h0,
  parameter logic [31:0] SIZE       = 32'h1000,
  parameter logic [31:0] OFFSET     = 32'h0,
  parameter int unsigned LEFT_SHIFT = 0
) (
  input  logic [31:0] i_addr,
  output logic        o_hit,
  output logic [31:0] o_xaddr
);

  logic [32:0] w_off;

  // Bit 32 is the borrow: set exactly when addr < BASE.
  assign w_off   = {1'b0, i_addr} - {1'b0, BASE};
  assign o_hit   = !w_off[32] && (w_off[31:0] < SIZE);
  assign o_xaddr = (w_off[31:0] << LEFT_SHIFT) + OFFSET;

endmodule

// File: rtl/axi_window_bridge.sv
// rtl/axi_window_bridge.sv - registered AXI4-Lite address-window bridge with DECERR containment
// Purpose: forwards in-window accesses (one read, one write outstanding) with translated
//          addresses; answers out-of-window accesses locally with DECERR and counts them.
// Ports: clk, rst (sync active-high); s (slave modport, upstream); m (master modport,
//        downstream); err_count (16, saturating DECERR count).
module axi_window_bridge
  import axi_lite_defs::*;
#(
  parameter logic [31:0] BASE       = 32'h0,
  parameter logic [31:0] SIZE       = 32'h1000,
  parameter logic [31:0] OFFSET     = 32'h0,
  parameter int unsigned LEFT_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_window_bridge_if.slave    s,
  axi_window_bridge_if.master   m,
  output logic [15:0]           err_count
);

  logic        w_ar_hit, w_aw_hit;
  logic [31:0] w_ar_xaddr, w_aw_xaddr;

  window_xlate #(.BASE(BASE), .SIZE(SIZE), .OFFSET(OFFSET), .LEFT_SHIFT(LEFT_SHIFT))
    u_ar_xlate (.i_addr(s.araddr), .o_hit(w_ar_hit), .o_xaddr(w_ar_xaddr));

  window_xlate #(.BASE(BASE), .SIZE(SIZE), .OFFSET(OFFSET), .LEFT_SHIFT(LEFT_SHIFT))
    u_aw_xlate (.i_addr(s.awaddr), .o_hit(w_aw_hit), .o_xaddr(w_aw_xaddr));

  // ---------------- read path ----------------
  logic [2:0]  r_rstate;
  logic [31:0] r_araddr, r_rdata;
  logic [2:0]  r_arprot;
  logic [1:0]  r_rresp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_araddr <= '0;
      r_arprot <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (s.arvalid) begin
          r_araddr <= w_ar_xaddr;
          r_arprot <= s.arprot;
          if (w_ar_hit) begin
            r_rstate <= R_ADDR;
          end else begin
            r_rdata  <= '0;
            r_rresp  <= RESP_DECERR;
            r_rstate <= R_ERR;
          end
        end
        R_ADDR: if (m.arready) r_rstate <= R_DATA;
        R_DATA: if (m.rvalid) begin
          r_rdata  <= m.rdata;
          r_rresp  <= m.rresp;
          r_rstate <= R_RESP;
        end
        R_RESP, R_ERR: if (s.rready) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s.arready = (r_rstate == R_IDLE);
  assign s.rvalid  = (r_rstate == R_RESP) || (r_rstate == R_ERR);
  assign s.rdata   = r_rdata;
  assign s.rresp   = r_rresp;
  assign m.araddr  = r_araddr;
  assign m.arprot  = r_arprot;
  assign m.arvalid = (r_rstate == R_ADDR);
  assign m.rready  = (r_rstate == R_DATA);

  // ---------------- write path ----------------
  logic [2:0]  r_wstate;
  logic        r_aw_got, r_w_got, r_aw_hit;
  logic [31:0] r_awaddr, r_wdata;
  logic [2:0]  r_awprot;
  logic [3:0]  r_wstrb;
  logic        r_m_awvalid, r_m_wvalid;
  logic [1:0]  r_bresp;

  logic w_aw_take, w_w_take, w_aw_have, w_w_have, w_hit_sel, w_aw_done, w_w_done;

  assign w_aw_take = (r_wstate == W_IDLE) && !r_aw_got && s.awvalid;
  assign w_w_take  = (r_wstate == W_IDLE) && !r_w_got  && s.wvalid;
  // "Held" includes a handshake happening this cycle, so same-cycle AW+W forwards next cycle.
  assign w_aw_have = r_aw_got || w_aw_take;
  assign w_w_have  = r_w_got  || w_w_take;
  assign w_hit_sel = r_aw_got ? r_aw_hit : w_aw_hit;
  assign w_aw_done = !r_m_awvalid || m.awready;
  assign w_w_done  = !r_m_wvalid  || m.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate    <= W_IDLE;
      r_aw_got    <= 1'b0;
      r_w_got     <= 1'b0;
      r_aw_hit    <= 1'b0;
      r_awaddr    <= '0;
      r_awprot    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_m_awvalid <= 1'b0;
      r_m_wvalid  <= 1'b0;
      r_bresp     <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_take) begin
            r_awaddr <= w_aw_xaddr;
            r_awprot <= s.awprot;
            r_aw_hit <= w_aw_hit;
            r_aw_got <= 1'b1;
          end
          if (w_w_take) begin
            r_wdata <= s.wdata;
            r_wstrb <= s.wstrb;
            r_w_got <= 1'b1;
          end
          if (w_aw_have && w_w_have) begin
            if (w_hit_sel) begin
              r_m_awvalid <= 1'b1;
              r_m_wvalid  <= 1'b1;
              r_wstate    <= W_FWD;
            end else begin
              r_bresp  <= RESP_DECERR;
              r_wstate <= W_ERR;
            end
          end
        end
        W_FWD: begin
          if (m.awready) r_m_awvalid <= 1'b0;
          if (m.wready)  r_m_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) r_wstate <= W_BWAIT;
        end
        W_BWAIT: if (m.bvalid) begin
          r_bresp  <= m.bresp;
          r_wstate <= W_RESP;
        end
        W_RESP, W_ERR: if (s.bready) begin
          r_aw_got <= 1'b0;
          r_w_got  <= 1'b0;
          r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign s.awready = (r_wstate == W_IDLE) && !r_aw_got;
  assign s.wready  = (r_wstate == W_IDLE) && !r_w_got;
  assign s.bvalid  = (r_wstate == W_RESP) || (r_wstate == W_ERR);
  assign s.bresp   = r_bresp;
  assign m.awaddr  = r_awaddr;
  assign m.awprot  = r_awprot;
  assign m.awvalid = r_m_awvalid;
  assign m.wdata   = r_wdata;
  assign m.wstrb   = r_wstrb;
  assign m.wvalid  = r_m_wvalid;
  assign m.bready  = (r_wstate == W_BWAIT);

  // ---------------- DECERR counter ----------------
  logic        w_r_err_hs, w_b_err_hs;
  logic [15:0] r_err_count;

  assign w_r_err_hs = (r_rstate == R_ERR) && s.rready;
  assign w_b_err_hs = (r_wstate == W_ERR) && s.bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else begin
      r_err_count <= sat_add16(r_err_count, {1'b0, w_r_err_hs} + {1'b0, w_b_err_hs});
    end
  end

  assign err_count = r_err_count;

endmodule

// File: tb/tb_axi_window_bridge.sv
// tb/tb_axi_window_bridge.sv - directed self-checking bench for axi_window_bridge
module tb_axi_window_bridge;
  import axi_lite_defs::*;

  localparam logic [31:0] P_BASE   = 32'h1000_0000;
  localparam logic [31:0] P_SIZE   = 32'h100;
  localparam logic [31:0] P_OFFSET = 32'h40;
  localparam int unsigned P_SHIFT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] err_count;

  axi_window_bridge_if s_bus ();
  axi_window_bridge_if m_bus ();

  axi_window_bridge #(
    .BASE(P_BASE), .SIZE(P_SIZE), .OFFSET(P_OFFSET), .LEFT_SHIFT(P_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .s(s_bus), .m(m_bus), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // downstream slave model knobs and records
  int          ar_stall     = 0;
  logic        sl_rvalid_en = 1'b1;
  logic        sl_awready_en = 1'b1;
  logic [31:0] sl_rdata     = 32'hCAFE_1234;
  logic [1:0]  sl_rresp     = RESP_OKAY;
  logic [1:0]  sl_bresp     = RESP_OKAY;
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, ar_wait = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  // Slave reacts on the falling edge to what the DUT registered on the rising edge.
  initial begin
    m_bus.arready = 0; m_bus.rvalid = 0; m_bus.rdata = 0; m_bus.rresp = 0;
    m_bus.awready = 0; m_bus.wready = 0; m_bus.bvalid = 0; m_bus.bresp = 0;
    forever begin
      @(negedge clk);
      if (m_bus.arvalid) begin
        if (ar_wait < ar_stall) begin
          m_bus.arready = 1'b0;
          ar_wait++;
        end else begin
          m_bus.arready = 1'b1;
          ar_hs++;
          last_araddr = m_bus.araddr;
        end
      end else begin
        m_bus.arready = 1'b0;
        ar_wait = 0;
      end
      m_bus.rvalid  = sl_rvalid_en;
      m_bus.rdata   = sl_rdata;
      m_bus.rresp   = sl_rresp;
      m_bus.awready = sl_awready_en;
      if (m_bus.awvalid && sl_awready_en) begin
        aw_hs++;
        last_awaddr = m_bus.awaddr;
      end
      m_bus.wready = 1'b1;
      if (m_bus.wvalid) begin
        w_hs++;
        last_wdata = m_bus.wdata;
        last_wstrb = m_bus.wstrb;
      end
      m_bus.bvalid = 1'b1;
      m_bus.bresp  = sl_bresp;
    end
  end

  // lat = cycle index of s_rvalid, counting the AR handshake cycle as 0
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int guard = 0;
    @(negedge clk);
    s_bus.araddr = addr; s_bus.arprot = 3'b010; s_bus.arvalid = 1'b1;
    while (!s_bus.arready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    s_bus.arvalid = 1'b0; s_bus.araddr = '0;
    lat = 1;
    while (!s_bus.rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    data = s_bus.rdata; resp = s_bus.rresp;
    @(negedge clk); s_bus.rready = 1'b1;
    @(posedge clk); #1; s_bus.rready = 1'b0;
  endtask

  // lat = cycle index of s_bvalid, counting the AW handshake cycle as 0
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, output logic [1:0] resp, output int lat);
    @(negedge clk);
    if (w_lead > 0) begin
      s_bus.wdata = data; s_bus.wstrb = strb; s_bus.wvalid = 1'b1;
      @(posedge clk); #1; s_bus.wvalid = 1'b0;
      repeat (w_lead - 1) @(posedge clk);
      @(negedge clk);
    end
    s_bus.awaddr = addr; s_bus.awprot = 3'b001; s_bus.awvalid = 1'b1;
    if (w_lead == 0) begin
      s_bus.wdata = data; s_bus.wstrb = strb; s_bus.wvalid = 1'b1;
    end
    @(posedge clk); #1;
    s_bus.awvalid = 1'b0; s_bus.wvalid = 1'b0;
    lat = 1;
    while (!s_bus.bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    resp = s_bus.bresp;
    @(negedge clk); s_bus.bready = 1'b1;
    @(posedge clk); #1; s_bus.bready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rr, br;
  int          rl, bl, aw0, w0, ar0;
  longint      t_r, t_w;

  initial begin
    s_bus.araddr = 0; s_bus.arprot = 0; s_bus.arvalid = 0; s_bus.rready = 0;
    s_bus.awaddr = 0; s_bus.awprot = 0; s_bus.awvalid = 0;
    s_bus.wdata = 0; s_bus.wstrb = 0; s_bus.wvalid = 0; s_bus.bready = 0;

    // reset state
    repeat (2) @(posedge clk); #1;
    check_eq("rst_s_arready", s_bus.arready, 1);
    check_eq("rst_s_awready", s_bus.awready, 1);
    check_eq("rst_s_wready", s_bus.wready, 1);
    check_eq("rst_valids", {s_bus.rvalid, s_bus.bvalid, m_bus.arvalid, m_bus.awvalid, m_bus.wvalid}, 0);
    check_eq("rst_m_readies", {m_bus.rready, m_bus.bready}, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_payload", {m_bus.araddr | m_bus.awaddr | m_bus.wdata | s_bus.rdata}, 0);
    check_eq("rst_resp_prot", {s_bus.rresp, s_bus.bresp, m_bus.arprot, m_bus.awprot, m_bus.wstrb}, 0);
    @(negedge clk); rst = 1'b0;

    // in-window read: 0x10 << 2 + 0x40 = 0x80
    ar0 = ar_hs;
    do_read(32'h1000_0010, rd, rr, rl);
    check_eq("rd_hit_araddr", last_araddr, 32'h80);
    check_eq("rd_hit_ar_count", ar_hs - ar0, 1);
    check_eq("rd_hit_data", rd, 32'hCAFE_1234);
    check_eq("rd_hit_resp", rr, RESP_OKAY);
    check_eq("rd_hit_latency", rl, 3);

    // just past window end, and just below BASE
    ar0 = ar_hs;
    do_read(32'h1000_0100, rd, rr, rl);
    check_eq("rd_miss_hi_resp", rr, RESP_DECERR);
    check_eq("rd_miss_hi_data", rd, 0);
    check_eq("rd_miss_hi_latency", rl, 1);
    do_read(32'h0FFF_FFFC, rd, rr, rl);
    check_eq("rd_miss_lo_resp", rr, RESP_DECERR);
    check_eq("rd_miss_lo_data", rd, 0);
    check_eq("rd_miss_no_m_ar", ar_hs - ar0, 0);
    #1 check_eq("err_after_2_miss", err_count, 2);

    // W three cycles ahead of AW: 0x4 << 2 + 0x40 = 0x50
    aw0 = aw_hs; w0 = w_hs;
    do_write(32'h1000_0004, 32'hA5A5_0F0F, 4'b0101, 3, br, bl);
    check_eq("wr_w_first_aw_count", aw_hs - aw0, 1);
    check_eq("wr_w_first_w_count", w_hs - w0, 1);
    check_eq("wr_w_first_awaddr", last_awaddr, 32'h50);
    check_eq("wr_w_first_wstrb", last_wstrb, 4'b0101);
    check_eq("wr_w_first_wdata", last_wdata, 32'hA5A5_0F0F);
    check_eq("wr_w_first_bresp", br, RESP_OKAY);
    check_eq("wr_w_first_latency", bl, 3);

    // last in-window byte, same-cycle AW/W, slave returns SLVERR: 0xFC << 2 + 0x40 = 0x430
    sl_bresp = RESP_SLVERR;
    do_write(32'h1000_00FC, 32'h1234_5678, 4'hF, 0, br, bl);
    check_eq("wr_slverr_awaddr", last_awaddr, 32'h430);
    check_eq("wr_slverr_bresp", br, RESP_SLVERR);
    check_eq("wr_same_cycle_latency", bl, 3);
    check_eq("wr_slverr_not_counted", err_count, 2);
    sl_bresp = RESP_OKAY;

    // read hit stalled 5 cycles downstream while a write miss completes
    ar_stall = 5; aw0 = aw_hs;
    fork
      begin do_read(32'h1000_0020, rd, rr, rl); t_r = $time; end
      begin do_write(32'h2000_0000, 32'hDEAD_BEEF, 4'hF, 0, br, bl); t_w = $time; end
    join
    ar_stall = 0;
    check_eq("conc_wr_bresp", br, RESP_DECERR);
    check_eq("conc_wr_latency", bl, 1);
    check_eq("conc_wr_no_m_aw", aw_hs - aw0, 0);
    check_eq("conc_wr_before_rd", (t_w < t_r), 1);
    check_eq("conc_rd_araddr", last_araddr, 32'hC0);
    check_eq("conc_rd_resp", rr, RESP_OKAY);
    check_eq("conc_rd_latency", rl, 8);
    check_eq("conc_err_count", err_count, 3);

    // reset while read sits in R_DATA and write in W_FWD
    sl_rvalid_en = 1'b0; sl_awready_en = 1'b0;
    @(negedge clk);
    s_bus.araddr = 32'h1000_0000; s_bus.arvalid = 1'b1;
    s_bus.awaddr = 32'h1000_0008; s_bus.awvalid = 1'b1;
    s_bus.wdata = 32'h0BAD_F00D; s_bus.wstrb = 4'hF; s_bus.wvalid = 1'b1;
    @(posedge clk); #1;
    s_bus.arvalid = 1'b0; s_bus.awvalid = 1'b0; s_bus.wvalid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("mid_in_r_data", m_bus.rready, 1);
    check_eq("mid_in_w_fwd", m_bus.awvalid, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_valids", {s_bus.rvalid, s_bus.bvalid, m_bus.arvalid, m_bus.awvalid, m_bus.wvalid}, 0);
    check_eq("mid_rst_m_readies", {m_bus.rready, m_bus.bready}, 0);
    check_eq("mid_rst_s_readies", {s_bus.arready, s_bus.awready, s_bus.wready}, 3'b111);
    check_eq("mid_rst_err_count", err_count, 0);
    @(negedge clk); rst = 1'b0; sl_rvalid_en = 1'b1; sl_awready_en = 1'b1;
    sl_rdata = 32'h5555_AAAA;
    do_read(32'h1000_00FC, rd, rr, rl);
    check_eq("post_rst_rd_araddr", last_araddr, 32'h430);
    check_eq("post_rst_rd_data", rd, 32'h5555_AAAA);
    check_eq("post_rst_rd_latency", rl, 3);

    // saturation: read and write misses in lockstep, 2 per 2 cycles
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    s_bus.araddr = 32'h0; s_bus.awaddr = 32'h0; s_bus.wdata = 32'h0; s_bus.wstrb = 4'hF;
    s_bus.arvalid = 1'b1; s_bus.awvalid = 1'b1; s_bus.wvalid = 1'b1;
    s_bus.rready = 1'b1; s_bus.bready = 1'b1;
    repeat (65534) @(posedge clk); #1;
    check_eq("sat_before_last", err_count, 16'hFFFE);
    repeat (2) @(posedge clk); #1;
    check_eq("sat_at_65536", err_count, 16'hFFFF);
    repeat (2) @(posedge clk); #1;
    check_eq("sat_holds", err_count, 16'hFFFF);
    s_bus.arvalid = 1'b0; s_bus.awvalid = 1'b0; s_bus.wvalid = 1'b0;
    s_bus.rready = 1'b0; s_bus.bready = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
